// File: rtl/txn_capture_pkg.sv
// txn_capture_pkg: shared capture entry layout and pointer sizing for the capture buffer
package txn_capture_pkg;
    localparam int DEF_DW  = 32;
    localparam int DEF_TSW = 16;
    typedef struct packed {
        logic [DEF_TSW-1:0] ts;
        logic [DEF_DW-1:0]  data;
    } cap_entry_t;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/cap_fifo.sv
// cap_fifo: synchronous FIFO with registered read port, flush and occupancy flags
module cap_fifo import txn_capture_pkg::*; #(
    parameter int W     = DEF_TSW + DEF_DW,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic                    rd_vld,
    output logic [W-1:0]            dout,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign level = wp - rp;
    assign full  = level == PW'(DEPTH);
    assign empty = level == '0;
    // Storage is deliberately unreset; only the pointers define validity.
    always_ff @(posedge clk)
        if (push && !clr) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp     <= '0;
            rp     <= '0;
            rd_vld <= 1'b0;
            dout   <= '0;
        end else if (clr) begin
            wp     <= '0;
            rp     <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                dout <= mem[rp[AW-1:0]];
            end
            rd_vld <= pop;
        end
    end
endmodule

// File: rtl/txn_capture_buf.sv
// txn_capture_buf: timestamps snooped valid/ready transfers and queues them for the monitor
module txn_capture_buf import txn_capture_pkg::*; #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 16,
    parameter int OVW   = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    tap_valid,
    input  logic                    tap_ready,
    input  logic [DW-1:0]           tap_data,
    input  logic                    rd_req,
    output logic                    rd_vld,
    output logic [DW-1:0]           rd_data,
    output logic [TSW-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic [OVW-1:0]          ovf_cnt
);
    logic [TSW-1:0]    ts;
    logic [TSW+DW-1:0] dout;
    logic              cap, pop, wr, drop;
    assign cap  = en & tap_valid & tap_ready;
    assign pop  = rd_req & ~empty;
    // A full FIFO still takes the capture when a pop frees a slot in the same cycle.
    assign wr   = cap & (~full | pop);
    assign drop = cap & full & ~pop;
    assign rd_data = dout[DW-1:0];
    assign rd_ts   = dout[TSW+DW-1:DW];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts      <= '0;
            ovf_cnt <= '0;
        end else if (clr) begin
            ts      <= '0;
            ovf_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
    cap_fifo #(.W(TSW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .push   (wr),
        .pop    (pop),
        .din    ({ts, tap_data}),
        .rd_vld (rd_vld),
        .dout   (dout),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );
endmodule

// File: tb/tb_txn_capture_buf.sv
// tb_txn_capture_buf: directed self-checking bench for txn_capture_buf
module tb_txn_capture_buf;
    localparam int DW = 8, DEPTH = 4, TSW = 4, OVW = 2;
    logic clk = 0, resetn = 0, en = 0, clr = 0, tap_valid = 0, tap_ready = 0, rd_req = 0;
    logic [DW-1:0] tap_data = '0;
    logic rd_vld, full, empty;
    logic [DW-1:0] rd_data;
    logic [TSW-1:0] rd_ts;
    logic [$clog2(DEPTH):0] level;
    logic [OVW-1:0] ovf_cnt;
    int checks = 0, failures = 0;

    txn_capture_buf #(.DW(DW), .DEPTH(DEPTH), .TSW(TSW), .OVW(OVW)) dut (
        .clk(clk), .resetn(resetn), .en(en), .clr(clr), .tap_valid(tap_valid),
        .tap_ready(tap_ready), .tap_data(tap_data), .rd_req(rd_req), .rd_vld(rd_vld),
        .rd_data(rd_data), .rd_ts(rd_ts), .level(level), .full(full), .empty(empty),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 0;
        repeat (2) tick;
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_rd_vld got %0h exp 0", rd_vld); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
        checks++; if (rd_ts !== '0) begin failures++; $display("FAIL reset_rd_ts got %0h exp 0", rd_ts); end
        checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty, full); end
        checks++; if (ovf_cnt !== '0) begin failures++; $display("FAIL reset_ovf got %0d exp 0", ovf_cnt); end
        resetn = 1;
    endtask

    task automatic test_capture;
        logic [DW-1:0] exp_d [3];
        logic [TSW-1:0] exp_t [3];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
        exp_t[0] = 4'd5;  exp_t[1] = 4'd6;  exp_t[2] = 4'd9;
        en = 1;
        repeat (5) tick;
        tap_valid = 1; tap_ready = 1; tap_data = 8'hA1; tick;
        checks++; if (level !== 1 || empty !== 1'b0) begin failures++; $display("FAIL push_visible got level=%0d empty=%0b exp 1/0", level, empty); end
        tap_data = 8'hA2; tick;
        tap_valid = 0; tick; tick;
        tap_valid = 1; tap_data = 8'hA3; tick;
        tap_valid = 0;
        checks++; if (level !== 3) begin failures++; $display("FAIL capture_level got %0d exp 3", level); end
        rd_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (rd_vld !== 1'b1 || rd_data !== exp_d[i] || rd_ts !== exp_t[i]) begin
                failures++; $display("FAIL pop%0d got vld=%0b data=%0h ts=%0d exp 1/%0h/%0d", i, rd_vld, rd_data, rd_ts, exp_d[i], exp_t[i]);
            end
        end
        checks++; if (level !== 0 || empty !== 1'b1) begin failures++; $display("FAIL drained got level=%0d empty=%0b exp 0/1", level, empty); end
        tick;
        checks++; if (rd_vld !== 1'b0 || level !== 0) begin failures++; $display("FAIL pop_empty got vld=%0b level=%0d exp 0/0", rd_vld, level); end
        rd_req = 0;
    endtask

    task automatic test_no_capture;
        tap_valid = 1; tap_ready = 0;
        repeat (10) tick;
        en = 0; tap_ready = 1; tick;
        tap_valid = 0; en = 1;
        checks++; if (level !== 0 || ovf_cnt !== 0) begin failures++; $display("FAIL no_capture got level=%0d ovf=%0d exp 0/0", level, ovf_cnt); end
    endtask

    task automatic test_overflow;
        tap_valid = 1; tap_ready = 1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            tap_data = 8'h10 + 8'(i); tick;
        end
        checks++; if (full !== 1'b1 || level !== DEPTH || ovf_cnt !== 3) begin
            failures++; $display("FAIL overflow got full=%0b level=%0d ovf=%0d exp 1/%0d/3", full, level, ovf_cnt, DEPTH);
        end
        tap_data = 8'h1F; tick;
        tap_valid = 0;
        checks++; if (ovf_cnt !== 3) begin failures++; $display("FAIL ovf_saturate got %0d exp 3", ovf_cnt); end
        rd_req = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick;
            checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin
                failures++; $display("FAIL ovf_drain%0d got vld=%0b data=%0h exp 1/%0h", i, rd_vld, rd_data, 8'h10 + 8'(i));
            end
        end
        rd_req = 0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got %0b exp 1", empty); end
    endtask

    task automatic test_full_push_pop;
        clr = 1; tick; clr = 0;
        checks++; if (ovf_cnt !== 0 || level !== 0) begin failures++; $display("FAIL clr_idle got ovf=%0d level=%0d exp 0/0", ovf_cnt, level); end
        tap_valid = 1; tap_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tap_data = 8'h20 + 8'(i); tick;
        end
        tap_data = 8'h24; rd_req = 1; tick;
        tap_valid = 0;
        checks++; if (level !== DEPTH || ovf_cnt !== 0 || rd_data !== 8'h20 || rd_vld !== 1'b1) begin
            failures++; $display("FAIL full_push_pop got level=%0d ovf=%0d data=%0h vld=%0b exp %0d/0/20/1", level, ovf_cnt, rd_data, rd_vld, DEPTH);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            tick;
            checks++; if (rd_data !== 8'h20 + 8'(i)) begin failures++; $display("FAIL fpp_drain%0d got %0h exp %0h", i, rd_data, 8'h20 + 8'(i)); end
        end
        rd_req = 0;
    endtask

    task automatic test_ts_wrap;
        clr = 1; tick; clr = 0;
        repeat (15) tick;
        tap_valid = 1; tap_ready = 1; tap_data = 8'h31; tick;
        tap_data = 8'h32; tick;
        tap_valid = 0; rd_req = 1; tick;
        checks++; if (rd_data !== 8'h31 || rd_ts !== 4'd15) begin failures++; $display("FAIL wrap_first got %0h/%0d exp 31/15", rd_data, rd_ts); end
        tick;
        checks++; if (rd_data !== 8'h32 || rd_ts !== 4'd0) begin failures++; $display("FAIL wrap_second got %0h/%0d exp 32/0", rd_data, rd_ts); end
        rd_req = 0;
    endtask

    task automatic test_clr_reset_midstream;
        tap_valid = 1; tap_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tap_data = 8'h40 + 8'(i); tick;
        end
        checks++; if (ovf_cnt !== 1) begin failures++; $display("FAIL pre_clr_ovf got %0d exp 1", ovf_cnt); end
        clr = 1; rd_req = 1; tick;
        clr = 0; rd_req = 0; tap_valid = 0;
        checks++; if (level !== 0 || rd_vld !== 1'b0 || ovf_cnt !== 0 || empty !== 1'b1) begin
            failures++; $display("FAIL clr_mid got level=%0d vld=%0b ovf=%0d empty=%0b exp 0/0/0/1", level, rd_vld, ovf_cnt, empty);
        end
        tap_valid = 1; tap_data = 8'h50; tick;
        tap_data = 8'h51; tick;
        tap_valid = 0; rd_req = 1; tick;
        checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h50) begin failures++; $display("FAIL pre_rst_pop got %0b/%0h exp 1/50", rd_vld, rd_data); end
        resetn = 0; #1;
        checks++; if (rd_vld !== 1'b0 || rd_data !== '0 || rd_ts !== '0 || level !== 0 || empty !== 1'b1 || full !== 1'b0 || ovf_cnt !== 0) begin
            failures++; $display("FAIL async_reset got vld=%0b data=%0h ts=%0d level=%0d empty=%0b full=%0b ovf=%0d exp reset values", rd_vld, rd_data, rd_ts, level, empty, full, ovf_cnt);
        end
        #1; resetn = 1; rd_req = 0;
        tap_valid = 1; tap_data = 8'h55; tick;
        tap_valid = 0; rd_req = 1; tick;
        rd_req = 0;
        checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h55 || rd_ts !== 4'd0) begin
            failures++; $display("FAIL post_rst_ts got %0b/%0h/%0d exp 1/55/0", rd_vld, rd_data, rd_ts);
        end
    endtask

    initial begin
        test_reset;
        test_capture;
        test_no_capture;
        test_overflow;
        test_full_push_pop;
        test_ts_wrap;
        test_clr_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
